// File: rtl/fault_trace_checker.sv
// Lockstep comparator for golden/faulty core traces: counts samples over a bounded
// run and records whether, where and how the faulty core first diverged.
module fault_trace_checker #(
    parameter int unsigned MAX_SAMPLES    = 1000,
    parameter bit          STOP_ON_DETECT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        valid,
    input  logic [31:0] golden_pc,
    input  logic [31:0] golden_result,
    input  logic [31:0] faulty_pc,
    input  logic [31:0] faulty_result,
    output logic        busy,
    output logic        done,
    output logic        detected,
    output logic [31:0] first_mismatch_idx,
    output logic [31:0] first_mismatch_pc,
    output logic [1:0]  mismatch_type,
    output logic [15:0] mismatch_count,
    output logic [31:0] sample_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        busy_q;
    logic        done_q;
    logic        detected_q;
    logic [31:0] first_idx_q;
    logic [31:0] first_pc_q;
    logic [1:0]  type_q;
    logic [15:0] mismatch_count_q;
    logic [31:0] sample_count_q;

    logic        pc_diff;
    logic        res_diff;
    logic        mismatch;
    logic [31:0] sample_count_d;
    logic [15:0] mismatch_count_d;
    logic        last_sample;

    always_comb begin
        pc_diff          = (golden_pc != faulty_pc);
        res_diff         = (golden_result != faulty_result);
        mismatch         = pc_diff | res_diff;
        sample_count_d   = sample_count_q + 32'd1;
        mismatch_count_d = (mismatch_count_q == 16'hFFFF) ? mismatch_count_q
                                                          : mismatch_count_q + 16'd1;
        last_sample      = (sample_count_d == 32'(MAX_SAMPLES));
    end

    // One block owns the FSM and every result register, so outputs are all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            detected_q       <= 1'b0;
            first_idx_q      <= 32'd0;
            first_pc_q       <= 32'd0;
            type_q           <= 2'b00;
            mismatch_count_q <= 16'd0;
            sample_count_q   <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    // A sample presented alongside start belongs to no run.
                    if (start) begin
                        state_q          <= S_RUN;
                        busy_q           <= 1'b1;
                        detected_q       <= 1'b0;
                        first_idx_q      <= 32'd0;
                        first_pc_q       <= 32'd0;
                        type_q           <= 2'b00;
                        mismatch_count_q <= 16'd0;
                        sample_count_q   <= 32'd0;
                    end
                end
                S_RUN: begin
                    if (valid) begin
                        sample_count_q <= sample_count_d;
                        if (mismatch) begin
                            mismatch_count_q <= mismatch_count_d;
                            if (!detected_q) begin
                                detected_q  <= 1'b1;
                                first_idx_q <= sample_count_q;
                                first_pc_q  <= golden_pc;
                                type_q      <= {res_diff, pc_diff};
                            end
                        end
                        if (last_sample || (STOP_ON_DETECT && mismatch)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign detected           = detected_q;
    assign first_mismatch_idx = first_idx_q;
    assign first_mismatch_pc  = first_pc_q;
    assign mismatch_type      = type_q;
    assign mismatch_count     = mismatch_count_q;
    assign sample_count       = sample_count_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_fault_trace_checker.sv
// Bench for fault_trace_checker: table of run scenarios with expected end-of-run
// results queued at start and compared when done pulses, plus reset/MAX=1 sequences.
module tb_fault_trace_checker;

    typedef struct packed {
        logic        det;
        logic [31:0] idx;
        logic [31:0] pc;
        logic [1:0]  typ;
        logic [15:0] mcnt;
        logic [31:0] scnt;
    } res_t;

    localparam int W = $bits(res_t);

    typedef struct {
        bit         use_stop;
        bit         start_valid;
        bit         bubbles;
        logic [7:0] pc_err;
        logic [7:0] res_err;
        res_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, valid;
    logic [31:0] gpc, gres, fpc, fres;

    logic        a_busy, a_done, a_det, b_busy, b_done, b_det, c_busy, c_done, c_det;
    logic [31:0] a_idx, a_pc, a_scnt, b_idx, b_pc, b_scnt, c_idx, c_pc, c_scnt;
    logic [1:0]  a_type, b_type, c_type, a_st, b_st, c_st;
    logic [15:0] a_mcnt, b_mcnt, c_mcnt;

    logic        sel;
    logic        s_busy, s_done, s_det;
    logic [31:0] s_idx, s_pc, s_scnt;
    logic [1:0]  s_type;
    logic [15:0] s_mcnt;

    logic [W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fault_trace_checker #(.MAX_SAMPLES(8), .STOP_ON_DETECT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .valid(valid),
        .golden_pc(gpc), .golden_result(gres), .faulty_pc(fpc), .faulty_result(fres),
        .busy(a_busy), .done(a_done), .detected(a_det), .first_mismatch_idx(a_idx),
        .first_mismatch_pc(a_pc), .mismatch_type(a_type), .mismatch_count(a_mcnt),
        .sample_count(a_scnt), .state_dbg(a_st));

    fault_trace_checker #(.MAX_SAMPLES(8), .STOP_ON_DETECT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .valid(valid),
        .golden_pc(gpc), .golden_result(gres), .faulty_pc(fpc), .faulty_result(fres),
        .busy(b_busy), .done(b_done), .detected(b_det), .first_mismatch_idx(b_idx),
        .first_mismatch_pc(b_pc), .mismatch_type(b_type), .mismatch_count(b_mcnt),
        .sample_count(b_scnt), .state_dbg(b_st));

    fault_trace_checker #(.MAX_SAMPLES(1), .STOP_ON_DETECT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .start(start), .valid(valid),
        .golden_pc(gpc), .golden_result(gres), .faulty_pc(fpc), .faulty_result(fres),
        .busy(c_busy), .done(c_done), .detected(c_det), .first_mismatch_idx(c_idx),
        .first_mismatch_pc(c_pc), .mismatch_type(c_type), .mismatch_count(c_mcnt),
        .sample_count(c_scnt), .state_dbg(c_st));

    assign s_busy = sel ? b_busy : a_busy;
    assign s_done = sel ? b_done : a_done;
    assign s_det  = sel ? b_det  : a_det;
    assign s_idx  = sel ? b_idx  : a_idx;
    assign s_pc   = sel ? b_pc   : a_pc;
    assign s_type = sel ? b_type : a_type;
    assign s_mcnt = sel ? b_mcnt : a_mcnt;
    assign s_scnt = sel ? b_scnt : a_scnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_sample(input int s, input bit perr, input bit rerr);
        valid = 1'b1;
        gpc   = 32'(s * 4);
        gres  = $urandom;
        fpc   = gpc ^ (perr ? 32'h100 : 32'h0);
        fres  = gres ^ {31'd0, rerr};
    endtask

    task automatic compare_done();
        res_t e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = res_t'(exp_q.pop_front());
            chk("detected", 32'(s_det), 32'(e.det));
            chk("first_idx", s_idx, e.idx);
            chk("first_pc", s_pc, e.pc);
            chk("mm_type", 32'(s_type), 32'(e.typ));
            chk("mm_count", 32'(s_mcnt), 32'(e.mcnt));
            chk("sample_count", s_scnt, e.scnt);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  end_s;
        bit  found;
        sel   = v.use_stop;
        end_s = 7;
        found = 1'b0;
        if (v.use_stop) begin
            for (int s = 0; s < 8; s++) begin
                if (!found && (v.pc_err[s] || v.res_err[s])) begin
                    end_s = s;
                    found = 1'b1;
                end
            end
        end
        exp_q.push_back(W'(v.exp));
        @(negedge clk);
        start = 1'b1;
        valid = v.start_valid;
        gpc   = 32'hDEAD_0000;
        fpc   = 32'h0;
        gres  = 32'h1;
        fres  = 32'h2;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b0;
        chk("busy_rise", 32'(s_busy), 32'd1);
        chk("start_clr_scnt", s_scnt, 32'd0);
        chk("start_clr_det", 32'(s_det), 32'd0);
        chk("no_done_start", 32'(s_done), 32'd0);
        for (int s = 0; s < 8; s++) begin
            if (v.bubbles && s > 0) repeat (2) @(negedge clk);
            drive_sample(s, v.pc_err[s], v.res_err[s]);
            @(negedge clk);
            valid = 1'b0;
            if (s == end_s) begin
                chk("done_pulse", 32'(s_done), 32'd1);
                chk("busy_fall", 32'(s_busy), 32'd0);
                compare_done();
            end else if (s < end_s) begin
                chk("no_early_done", 32'(s_done), 32'd0);
            end
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(s_done), 32'd0);
        chk("hold_scnt", s_scnt, v.exp.scnt);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 0, 0, 8'h00, 8'h00, '{1'b0, 32'd0, 32'h00, 2'b00, 16'd0, 32'd8}};
        vecs[1] = '{0, 0, 0, 8'h20, 8'h08, '{1'b1, 32'd3, 32'h0C, 2'b10, 16'd2, 32'd8}};
        vecs[2] = '{1, 0, 0, 8'h44, 8'h44, '{1'b1, 32'd2, 32'h08, 2'b11, 16'd1, 32'd3}};
        vecs[3] = '{0, 0, 1, 8'h00, 8'h00, '{1'b0, 32'd0, 32'h00, 2'b00, 16'd0, 32'd8}};
        vecs[4] = '{0, 0, 0, 8'h81, 8'h00, '{1'b1, 32'd0, 32'h00, 2'b01, 16'd2, 32'd8}};
        vecs[5] = '{1, 0, 0, 8'h00, 8'h80, '{1'b1, 32'd7, 32'h1C, 2'b10, 16'd1, 32'd8}};
        vecs[6] = '{0, 0, 0, 8'hFF, 8'hFF, '{1'b1, 32'd0, 32'h00, 2'b11, 16'd8, 32'd8}};
        vecs[7] = '{0, 1, 0, 8'h00, 8'h00, '{1'b0, 32'd0, 32'h00, 2'b00, 16'd0, 32'd8}};

        rst = 1'b1; start = 1'b0; valid = 1'b0; sel = 1'b0;
        gpc = '0; gres = '0; fpc = '0; fres = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_det", 32'(a_det), 32'd0);
        chk("rst_idx", a_idx, 32'd0);
        chk("rst_pc", a_pc, 32'd0);
        chk("rst_type", 32'(a_type), 32'd0);
        chk("rst_mcnt", 32'(a_mcnt), 32'd0);
        chk("rst_scnt", a_scnt, 32'd0);
        chk("rst_state", 32'(a_st), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset mid-run after 4 samples with a mismatch already recorded.
        sel = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            drive_sample(s, s == 1, 1'b0);
            @(negedge clk);
        end
        valid = 1'b0;
        chk("pre_rst_det", 32'(a_det), 32'd1);
        chk("pre_rst_scnt", a_scnt, 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        chk("abort_det", 32'(a_det), 32'd0);
        chk("abort_idx", a_idx, 32'd0);
        chk("abort_pc", a_pc, 32'd0);
        chk("abort_type", 32'(a_type), 32'd0);
        chk("abort_mcnt", 32'(a_mcnt), 32'd0);
        chk("abort_scnt", a_scnt, 32'd0);
        chk("abort_state", 32'(a_st), 32'd0);
        run_vec(vecs[1]);

        // MAX_SAMPLES=1: one accepted sample ends the run, later samples ignored.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("c_busy", 32'(c_busy), 32'd1);
        drive_sample(5, 1'b0, 1'b1);
        @(negedge clk);
        valid = 1'b0;
        chk("c_done", 32'(c_done), 32'd1);
        chk("c_busy_fall", 32'(c_busy), 32'd0);
        chk("c_det", 32'(c_det), 32'd1);
        chk("c_scnt", c_scnt, 32'd1);
        chk("c_type", 32'(c_type), 32'd2);
        chk("c_pc", c_pc, 32'h14);
        chk("c_mcnt", 32'(c_mcnt), 32'd1);
        drive_sample(6, 1'b1, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        chk("c_done_once", 32'(c_done), 32'd0);
        chk("c_hold_scnt", c_scnt, 32'd1);
        chk("c_hold_mcnt", 32'(c_mcnt), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fault_trace_checker.md
# fault_trace_checker

Lockstep trace checker for fault campaigns: it takes the per-cycle PC and writeback-result streams from a golden single-cycle core and a faulty single-cycle core. It compares them sample by sample over a bounded run window. It records whether the fault became architecturally visible, the first divergence point and a mismatch count. It sits beside the two core tops in the campaign testbench/top and consumes their `PC_Top_Out`/`Result_Out` trace outputs.

## Interface
- `MAX_SAMPLES`, default 1000: samples per run; legal range 1..2^32-1.
- `STOP_ON_DETECT`, default 0: 1 ends the run at the first mismatching sample.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `start` in 1: begin a new run; sampled in IDLE and DONE, ignored in RUN.
- `valid` in 1: both cores completed an instruction this cycle; trace inputs are meaningful.
- `golden_pc` in 32: golden core PC.
- `golden_result` in 32: golden core writeback result.
- `faulty_pc` in 32: faulty core PC.
- `faulty_result` in 32: faulty core writeback result.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on entry to DONE.
- `detected` out 1: sticky; at least one mismatch seen in the current run.
- `first_mismatch_idx` out 32: 0-based sample index of the first mismatch.
- `first_mismatch_pc` out 32: `golden_pc` at the first mismatch.
- `mismatch_type` out 2: bit0 = PC differed and bit1 = result differed, both captured at the first mismatch.
- `mismatch_count` out 16: mismatching samples in the run; saturates at 16'hFFFF.
- `sample_count` out 32: samples accepted in the run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on `start`. The entry cycle clears `detected`, `first_mismatch_*`, `mismatch_type`, `mismatch_count` and `sample_count`.
- RUN: a sample is accepted when `valid`=1. A sample mismatches if `golden_pc`!=`faulty_pc` or `golden_result`!=`faulty_result`.
- Accepted sample behaviour:
  - `sample_count` increments.
  - A mismatch increments `mismatch_count` (saturating).
  - On the first mismatch of the run, `detected`=1 and `first_mismatch_idx`=the pre-increment `sample_count`. `first_mismatch_pc` and `mismatch_type` are captured in the same cycle.
  - Later mismatches never overwrite the first-mismatch fields.
- RUN -> DONE when the accepted sample is number `MAX_SAMPLES` (`sample_count` becomes `MAX_SAMPLES`). It also goes RUN -> DONE when `STOP_ON_DETECT`=1 and the accepted sample mismatches; either condition alone is sufficient.
- DONE: all result outputs hold, `valid` is ignored. `start` -> RUN with the same clearing as from IDLE.
- `start` in RUN has no effect. A `start` with `valid` in the same cycle in IDLE/DONE does not accept that sample.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `detected`=0, `first_mismatch_idx`=0, `first_mismatch_pc`=0, `mismatch_type`=2'b00, `mismatch_count`=0, `sample_count`=0.
- `rst` mid-run aborts to IDLE with reset values next cycle; no `done` pulse.
- `busy` rises the cycle after `start` is sampled.
- Counters, `detected` and the first-mismatch fields update the cycle after the accepted sample's edge, which is 1-cycle latency.
- `done` is high for exactly one cycle, coincident with the state first reading DONE. That is the same cycle the final sample's updates become visible, so a mismatch on the last sample shows `detected`=1 together with `done`. `busy` falls in that cycle.
- Bubbles (`valid`=0) in RUN advance nothing; the run length is counted in samples, not cycles.
- With `MAX_SAMPLES`=1, a single accepted sample ends the run.
- `mismatch_count` at 16'hFFFF stays there; `detected` stays 1.

## Test plan
- Identical streams, `MAX_SAMPLES`=8, 8 `valid` samples:
  - `done` pulses 1 cycle after the 8th sample.
  - `detected`=0, `mismatch_count`=0, `sample_count`=8.
- Result mismatch at sample idx 3 (golden_pc=0x0C, faulty_result^=1) and PC mismatch at idx 5, `STOP_ON_DETECT`=0:
  - `first_mismatch_idx`=3, `first_mismatch_pc`=0x0C, `mismatch_type`=2'b10.
  - `mismatch_count`=2, `sample_count`=8.
- `STOP_ON_DETECT`=1 with PC and result both differing at idx 2:
  - `done` is asserted 1 cycle after that sample.
  - `sample_count`=3, `mismatch_type`=2'b11, and the remaining samples are ignored.
- `valid` bubbles interleaved (valid pattern 1,0,0,1,...) with 8 samples: `done` follows only the 8th accepted sample, and `sample_count`=8.
- `rst` asserted mid-run after 4 samples with `detected`=1:
  - Next cycle all outputs are at reset values, with no `done` pulse.
  - A new `start` runs cleanly from 0.
- Back-to-back runs:
  - `start` in DONE clears prior `detected`/counts.
  - A `start` with `valid` in the same cycle leaves `sample_count`=0.
